psram_bram_resp: RTL and testbench
==================================

// Module: psram_bram_resp
// PURPOSE
//  Responder end of the psclk-domain PSRAM command interface (psram_cmd/cmd_en/addr/wdata/rdata/rvalid/ready).
//  Emulates the PSRAM controller with on-chip block RAM, serving 16-word (64-byte) line bursts to the cache bridge.
//  Used for board bring-up and regression without the external PSRAM; drop-in for the controller's user side.
// PARAMETERS
//  BURST_WORDS  16  words per burst; fixed to one 64-byte cache line (16 x 32 bit)
//  MEM_AW       12  word-address width of backing RAM (2^MEM_AW words); addr bits above [MEM_AW+1:2] ignored (alias)
//  RD_LAT       4   cycles from read-command accept to first rvalid beat (min 1)
// PORTS
//  psclk              in   1   single clock, all logic rising edge
//  PSRST_N            in   1   synchronous reset, active low
//  psram_cmd          in   1   1=write, 0=read; sampled at accept
//  psram_cmd_en       in   1   command request; held by initiator until it sees ready
//  psram_addr         in   23  byte address; sampled at accept
//  psram_wdata        in   32  write data beats
//  psram_mask         in   4   byte mask per beat, 1=byte NOT written
//  psram_rdata        out  32  read data
//  psram_rvalid       out  1   read beat valid
//  psram_ready        out  1   responder idle, command may be accepted
//  psram_ready_clone  out  1   duplicate of psram_ready (separate register, identical value)
// BEHAVIOUR
//  Reset (PSRST_N=0 at edge): state=IDLE, beat cnt=0, ready/ready_clone=0, rvalid=0, rdata=0. RAM contents kept.
//  ready/ready_clone rise the first cycle after PSRST_N returns high; registered, equal in every cycle.
//  Accept: cycle with cmd_en & ready. Latch cmd, word ptr=addr[MEM_AW+1:2]; ready drops next cycle.
//  cmd_en still high during the cycle after accept is ignored (ready=0); no double accept.
//  States:
//   IDLE   : ready=1. accept & cmd=1 -> WBEAT; accept & cmd=0 -> RLAT (lat cnt=0).
//   WBEAT  : beats k=0..15 taken on the 16 consecutive cycles starting 1 cycle after accept; no gaps allowed.
//            Each beat writes RAM[base | ((ptr+k) mod 16)] with per-byte enable ~mask. k==15 -> IDLE.
//   RLAT   : count RD_LAT-1 cycles -> RBURST.
//   RBURST : 16 beats; rdata=RAM word in same wrap order, rvalid=1 per beat; after beat 15 -> IDLE.
//  Wrap: burst ordering wraps inside the 64-byte line (addr[5:2] start, mod 16); bits above [5] fixed.
//  Read latency: first rvalid exactly RD_LAT cycles after accept edge; last beat at RD_LAT+15 (no stalls).
//  ready returns high the cycle after last write beat / last rvalid; back-to-back accept then legal.
//  Read-after-write to same line: returns newly written data (write completes before ready re-asserts).
//  Counters 4 bit, wrap 15->0 naturally; beat count only advances on actual beats.
//  Reset mid-burst: burst abandoned; partial writes already done stay in RAM; no further rvalid.
//  RAM: 1-cycle synchronous read, pipelined so rvalid/rdata aligned; BSRAM-inferable (byte-enable write).
// CONFIGURATION
//  PSRAM_RESP_STALL_EN defined: in RBURST a 16-bit LFSR (seed 16'hACE1 at reset, x^16+x^14+x^13+x^11+1)
//   inserts idle cycles (rvalid=0, rdata held) when lfsr[0]=1, max 3 consecutive; beat order/data unchanged;
//   exercises initiator tolerance of non-contiguous rvalid. Write side unaffected.
//  Not defined: rvalid contiguous for all 16 beats, timing as above; LFSR not built.
// TESTING
//  T1 reset: hold PSRST_N=0 4 cycles -> ready=0,rvalid=0,rdata=0; release -> ready=ready_clone=1 next cycle.
//  T2 line write/read: write addr 23'h000040 words 32'h1000_0000+k, mask 0 -> read 23'h000040:
//     first rvalid RD_LAT cycles after accept, 16 beats 32'h1000_0000..32'h1000_000F in order.
//  T3 wrap: read addr 23'h000078 (word 14) after T2 -> beats 0x..0E,0x..0F,0x..00,..,0x..0D.
//  T4 mask: write line 23'h000080 all 32'hFFFF_FFFF, then rewrite beat data 32'h1234_5678 mask 4'b1010
//     -> read back 32'hFF34_FF78 every word.
//  T5 handshake: cmd_en held 3 cycles after accept & during burst -> exactly one command executed;
//     second command issued on ready re-rise is accepted same cycle.
//  T6 reset mid-read at beat 5 -> rvalid=0 from next cycle, ready=1 after release, next read returns RAM data.

Source files
------------

// File: rtl/psram_bram_resp.sv
// Block-RAM stand-in for the PSRAM controller user side: 16-word wrapped line bursts.
// Optional macro PSRAM_RESP_STALL_EN adds LFSR-driven idle cycles inside read bursts.
module psram_bram_resp #(
  parameter int BURST_WORDS = 16,
  parameter int MEM_AW      = 12,
  parameter int RD_LAT      = 4
) (
  input  logic        psclk,
  input  logic        PSRST_N,
  input  logic        psram_cmd,
  input  logic        psram_cmd_en,
  input  logic [22:0] psram_addr,
  input  logic [31:0] psram_wdata,
  input  logic [3:0]  psram_mask,
  output logic [31:0] psram_rdata,
  output logic        psram_rvalid,
  output logic        psram_ready,
  output logic        psram_ready_clone
);

  typedef enum logic [1:0] {IDLE, WBEAT, RLAT, RBURST} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [MEM_AW-1:0]  r_ptr;
  logic [3:0]         r_beat;
  logic [7:0]         r_latCnt;
  logic               r_ready;
  logic               r_readyClone;
  logic [31:0]        r_rdata;
  logic [31:0]        r_mem [0:(1<<MEM_AW)-1];

  logic               w_accept;
  logic               w_stall;
  logic               w_beatGo;
  logic               w_lastWrBeat;
  logic               w_lastRdBeat;
  logic               w_latDone;
  logic               w_rdEn;
  logic               w_readyNext;
  logic [3:0]         w_wrOff;
  logic [3:0]         w_rdIdx;
  logic [3:0]         w_rdOff;
  logic [MEM_AW-1:0]  w_wrAddr;
  logic [MEM_AW-1:0]  w_rdAddr;
  logic               w_unusedAddr;

  assign w_unusedAddr = ^{psram_addr[22:MEM_AW+2], psram_addr[1:0]};

  assign w_accept     = psram_cmd_en & r_ready;
  assign w_beatGo     = (r_state == RBURST) & ~w_stall;
  assign w_lastWrBeat = (r_state == WBEAT) & (r_beat == 4'(BURST_WORDS-1));
  assign w_lastRdBeat = w_beatGo & (r_beat == 4'(BURST_WORDS-1));
  assign w_latDone    = (r_state == RLAT) & (r_latCnt == 8'(RD_LAT-1));

  // Burst order wraps inside the 64-byte line; the line base stays fixed.
  assign w_wrOff  = r_ptr[3:0] + r_beat;
  assign w_wrAddr = {r_ptr[MEM_AW-1:4], w_wrOff};

  // The RAM read runs one beat ahead so registered data lines up with a combinational rvalid.
  assign w_rdIdx  = (r_state == RLAT) ? 4'd0 : (r_beat + 4'd1);
  assign w_rdOff  = r_ptr[3:0] + w_rdIdx;
  assign w_rdAddr = {r_ptr[MEM_AW-1:4], w_rdOff};
  assign w_rdEn   = w_latDone | (w_beatGo & ~w_lastRdBeat);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = psram_cmd ? WBEAT : RLAT;
      WBEAT:   if (w_lastWrBeat) w_nextState = IDLE;
      RLAT:    if (w_latDone) w_nextState = RBURST;
      RBURST:  if (w_lastRdBeat) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    w_readyNext = (w_nextState == IDLE);
  end

  always_ff @(posedge psclk) begin
    if (!PSRST_N) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_beat       <= 4'd0;
      r_latCnt     <= 8'd0;
      r_ready      <= 1'b0;
      r_readyClone <= 1'b0;
      r_rdata      <= 32'd0;
    end else begin
      r_state      <= w_nextState;
      r_ready      <= w_readyNext;
      r_readyClone <= w_readyNext;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ptr    <= psram_addr[MEM_AW+1:2];
            r_beat   <= 4'd0;
            r_latCnt <= 8'd0;
          end
        end
        WBEAT:   r_beat   <= r_beat + 4'd1;
        RLAT:    r_latCnt <= r_latCnt + 8'd1;
        RBURST:  if (w_beatGo) r_beat <= r_beat + 4'd1;
        default: r_beat   <= 4'd0;
      endcase
      if (w_rdEn) r_rdata <= r_mem[w_rdAddr];
    end
  end

  // Byte-enable write port; RAM contents survive reset.
  always_ff @(posedge psclk) begin
    if (PSRST_N && (r_state == WBEAT)) begin
      for (int b = 0; b < 4; b++) begin
        if (!psram_mask[b]) r_mem[w_wrAddr][8*b +: 8] <= psram_wdata[8*b +: 8];
      end
    end
  end

`ifdef PSRAM_RESP_STALL_EN
  logic [15:0] r_lfsr;
  logic [1:0]  r_stallRun;
  logic        w_lfsrFb;

  assign w_lfsrFb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_stall  = (r_state == RBURST) & r_lfsr[0] & (r_stallRun != 2'd3);

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1; idle runs are capped at three cycles.
  always_ff @(posedge psclk) begin
    if (!PSRST_N) begin
      r_lfsr     <= 16'hACE1;
      r_stallRun <= 2'd0;
    end else if (r_state == RBURST) begin
      r_lfsr     <= {w_lfsrFb, r_lfsr[15:1]};
      r_stallRun <= w_stall ? (r_stallRun + 2'd1) : 2'd0;
    end else begin
      r_stallRun <= 2'd0;
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  assign psram_rdata       = r_rdata;
  assign psram_rvalid      = w_beatGo;
  assign psram_ready       = r_ready;
  assign psram_ready_clone = r_readyClone;

endmodule

// File: tb/tb_psram_bram_resp.sv
// Directed bench for psram_bram_resp: reset, line write/read, wrap, mask, handshake, reset mid-read.
module tb_psram_bram_resp;

  localparam int RD_LAT = 4;

  logic        psclk = 1'b0;
  logic        PSRST_N;
  logic        psram_cmd;
  logic        psram_cmd_en;
  logic [22:0] psram_addr;
  logic [31:0] psram_wdata;
  logic [3:0]  psram_mask;
  logic [31:0] psram_rdata;
  logic        psram_rvalid;
  logic        psram_ready;
  logic        psram_ready_clone;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expBeats [16];

  psram_bram_resp #(.BURST_WORDS(16), .MEM_AW(12), .RD_LAT(RD_LAT)) dut (
    .psclk             (psclk),
    .PSRST_N           (PSRST_N),
    .psram_cmd         (psram_cmd),
    .psram_cmd_en      (psram_cmd_en),
    .psram_addr        (psram_addr),
    .psram_wdata       (psram_wdata),
    .psram_mask        (psram_mask),
    .psram_rdata       (psram_rdata),
    .psram_rvalid      (psram_rvalid),
    .psram_ready       (psram_ready),
    .psram_ready_clone (psram_ready_clone)
  );

  always #5 psclk = ~psclk;

  // Drives a command and returns at the falling edge just after the accept edge.
  task automatic issueCmd(input logic cmd, input logic [22:0] addr, input bit hold);
    int waitCnt;
    waitCnt      = 0;
    psram_cmd    = cmd;
    psram_addr   = addr;
    psram_cmd_en = 1'b1;
    while (psram_ready !== 1'b1 && waitCnt < 64) begin
      @(negedge psclk);
      waitCnt++;
    end
    checks++;
    if (psram_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_timeout: got %b expected 1", psram_ready);
    end
    @(negedge psclk);
    if (!hold) psram_cmd_en = 1'b0;
  endtask

  task automatic writeBeats(input logic [31:0] base, input bit inc, input logic [3:0] mask,
                            input string tag);
    for (int k = 0; k < 16; k++) begin
      psram_wdata = inc ? (base + 32'(k)) : base;
      psram_mask  = mask;
      checks++;
      if (psram_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s_wready beat=%0d: got %b expected 0", tag, k, psram_ready);
      end
      @(negedge psclk);
    end
    psram_wdata = 32'd0;
    psram_mask  = 4'd0;
    checks++;
    if (psram_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_wdone_ready: got %b expected 1", tag, psram_ready);
    end
  endtask

  task automatic doWrite(input logic [22:0] addr, input logic [31:0] base, input bit inc,
                         input logic [3:0] mask, input string tag);
    issueCmd(1'b1, addr, 1'b0);
    writeBeats(base, inc, mask, tag);
  endtask

  // Cycle c counts falling edges after the accept edge (c=0 is the first).
  task automatic readBeats(input string tag);
    logic expV;
    logic expR;
    for (int c = 0; c <= RD_LAT + 16; c++) begin
      expV = (c >= RD_LAT) && (c < RD_LAT + 16);
      expR = (c == RD_LAT + 16);
      checks++;
      if (psram_rvalid !== expV) begin
        errors++;
        $display("[TB] FAIL %s_rvalid c=%0d: got %b expected %b", tag, c, psram_rvalid, expV);
      end
      checks++;
      if (psram_ready !== expR || psram_ready_clone !== expR) begin
        errors++;
        $display("[TB] FAIL %s_ready c=%0d: got %b/%b expected %b", tag, c, psram_ready,
                 psram_ready_clone, expR);
      end
      if (expV) begin
        checks++;
        if (psram_rdata !== expBeats[c-RD_LAT]) begin
          errors++;
          $display("[TB] FAIL %s_rdata beat=%0d: got %h expected %h", tag, c - RD_LAT,
                   psram_rdata, expBeats[c-RD_LAT]);
        end
      end
      if (c < RD_LAT + 16) @(negedge psclk);
    end
  endtask

  task automatic setLineExp(input int start);
    for (int k = 0; k < 16; k++) expBeats[k] = 32'h1000_0000 + 32'((start + k) % 16);
  endtask

  task automatic test_reset;
    PSRST_N = 1'b0;
    repeat (4) @(negedge psclk);
    checks++;
    if (psram_ready !== 1'b0 || psram_ready_clone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b/%b expected 0/0", psram_ready, psram_ready_clone);
    end
    checks++;
    if (psram_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rvalid: got %b expected 0", psram_rvalid);
    end
    checks++;
    if (psram_rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h expected 00000000", psram_rdata);
    end
    PSRST_N = 1'b1;
    @(negedge psclk);
    checks++;
    if (psram_ready !== 1'b1 || psram_ready_clone !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release_ready: got %b/%b expected 1/1", psram_ready, psram_ready_clone);
    end
  endtask

  task automatic test_line_write_read;
    doWrite(23'h000040, 32'h1000_0000, 1'b1, 4'b0000, "t2_wr");
    setLineExp(0);
    issueCmd(1'b0, 23'h000040, 1'b0);
    readBeats("t2_rd");
  endtask

  task automatic test_wrap;
    setLineExp(14);
    issueCmd(1'b0, 23'h000078, 1'b0);
    readBeats("t3_wrap");
  endtask

  // Address bits above the RAM word range alias onto the same line.
  task automatic test_alias;
    setLineExp(3);
    issueCmd(1'b0, 23'h00404C, 1'b0);
    readBeats("alias");
  endtask

  task automatic test_mask;
    doWrite(23'h000080, 32'hFFFF_FFFF, 1'b0, 4'b0000, "t4_fill");
    doWrite(23'h000080, 32'h1234_5678, 1'b0, 4'b1010, "t4_mask");
    for (int k = 0; k < 16; k++) expBeats[k] = 32'hFF34_FF78;
    issueCmd(1'b0, 23'h000080, 1'b0);
    readBeats("t4_rd");
  endtask

  task automatic test_handshake;
    setLineExp(0);
    issueCmd(1'b0, 23'h000040, 1'b1);
    readBeats("t5_first");
    psram_addr = 23'h000078;
    @(negedge psclk);
    psram_cmd_en = 1'b0;
    setLineExp(14);
    readBeats("t5_second");
  endtask

  task automatic test_reset_mid_read;
    setLineExp(0);
    issueCmd(1'b0, 23'h000040, 1'b0);
    repeat (RD_LAT + 5) @(negedge psclk);
    checks++;
    if (psram_rvalid !== 1'b1 || psram_rdata !== 32'h1000_0005) begin
      errors++;
      $display("[TB] FAIL t6_beat5: got %b/%h expected 1/10000005", psram_rvalid, psram_rdata);
    end
    PSRST_N = 1'b0;
    @(negedge psclk);
    checks++;
    if (psram_rvalid !== 1'b0 || psram_ready !== 1'b0 || psram_rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL t6_reset_outputs: got %b/%b/%h expected 0/0/00000000", psram_rvalid,
               psram_ready, psram_rdata);
    end
    @(negedge psclk);
    checks++;
    if (psram_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t6_no_rvalid: got %b expected 0", psram_rvalid);
    end
    PSRST_N = 1'b1;
    @(negedge psclk);
    checks++;
    if (psram_ready !== 1'b1 || psram_ready_clone !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t6_ready: got %b/%b expected 1/1", psram_ready, psram_ready_clone);
    end
    issueCmd(1'b0, 23'h000040, 1'b0);
    readBeats("t6_reread");
  endtask

  initial begin
    PSRST_N      = 1'b0;
    psram_cmd    = 1'b0;
    psram_cmd_en = 1'b0;
    psram_addr   = 23'd0;
    psram_wdata  = 32'd0;
    psram_mask   = 4'd0;
    @(negedge psclk);
    test_reset();
    test_line_write_read();
    test_wrap();
    test_alias();
    test_mask();
    test_handshake();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
